// File: rtl/axi_st_pkg.sv
// axi_st_pkg: shared widths, beat layout and helper for the AXI-Stream FIFO
package axi_st_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_TID_W = 8;
  localparam int DEF_TDEST_W = 8;
  localparam int DEF_TUSER_W = 8;
  localparam int DEF_DEPTH = 16;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DATA_W/8-1:0] strb;
    logic [DEF_DATA_W/8-1:0] keep;
    logic last;
    logic [DEF_TID_W-1:0] id;
    logic [DEF_TDEST_W-1:0] dest;
    logic [DEF_TUSER_W-1:0] user;
  } def_beat_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/axi_st_fifo_mem.sv
// axi_st_fifo_mem: DEPTH x W register array, one write port, combinational read port
module axi_st_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // store an accepted beat; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_st_fifo.sv
// axi_st_fifo: AXI-Stream beat FIFO with registered handshakes, level and packet count
module axi_st_fifo
  import axi_st_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYMBOL_NUM = DATA_W / 8,
  parameter int TID_W = DEF_TID_W,
  parameter int TDEST_W = DEF_TDEST_W,
  parameter int TUSER_W = DEF_TUSER_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [SYMBOL_NUM-1:0] s_tstrb,
  input  logic [SYMBOL_NUM-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic [TID_W-1:0]      s_tid,
  input  logic [TDEST_W-1:0]    s_tdest,
  input  logic [TUSER_W-1:0]    s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [SYMBOL_NUM-1:0] m_tstrb,
  output logic [SYMBOL_NUM-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic [TID_W-1:0]      m_tid,
  output logic [TDEST_W-1:0]    m_tdest,
  output logic [TUSER_W-1:0]    m_tuser,
  output logic [CNT_W-1:0]      level,
  output logic [CNT_W-1:0]      pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYMBOL_NUM-1:0] strb;
    logic [SYMBOL_NUM-1:0] keep;
    logic last;
    logic [TID_W-1:0] id;
    logic [TDEST_W-1:0] dest;
    logic [TUSER_W-1:0] user;
  } beat_t;
  beat_t w_wbeat, w_rbeat;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_level, r_pkt_cnt, w_level_nxt, w_pkt_nxt;
  logic r_s_tready, r_m_tvalid, w_push, w_pop, w_pin, w_pout;
  assign w_push = s_tvalid & r_s_tready;
  assign w_pop = r_m_tvalid & m_tready;
  assign w_pin = w_push & s_tlast;
  assign w_pout = w_pop & w_rbeat.last;
  assign w_wbeat = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
                     id: s_tid, dest: s_tdest, user: s_tuser};
  // next occupancy and packet count; a simultaneous push and pop cancel out
  always_comb begin
    w_level_nxt = (w_push & ~w_pop) ? r_level + 1'b1 : (~w_push & w_pop) ? r_level - 1'b1 : r_level;
    w_pkt_nxt = (w_pin & ~w_pout) ? r_pkt_cnt + 1'b1 : (~w_pin & w_pout) ? r_pkt_cnt - 1'b1 : r_pkt_cnt;
  end
  // pointers, counters and handshake flags; handshakes are registered from the next level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
      r_pkt_cnt <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_level <= w_level_nxt;
      r_pkt_cnt <= w_pkt_nxt;
      r_s_tready <= w_level_nxt != CNT_W'(DEPTH);
      r_m_tvalid <= w_level_nxt != '0;
    end
  end
  axi_st_fifo_mem #(.W($bits(beat_t)), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk    (clk),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata(w_wbeat),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rbeat)
  );
  assign s_tready = r_s_tready;
  assign m_tvalid = r_m_tvalid;
  assign level = r_level;
  assign pkt_cnt = r_pkt_cnt;
  assign m_tdata = w_rbeat.data;
  assign m_tstrb = w_rbeat.strb;
  assign m_tkeep = w_rbeat.keep;
  assign m_tlast = w_rbeat.last;
  assign m_tid = w_rbeat.id;
  assign m_tdest = w_rbeat.dest;
  assign m_tuser = w_rbeat.user;
endmodule
